// File: rtl/gf8_mul_arbiter.sv
// gf8_mul_arbiter: round-robin arbiter sharing one GF(2^8) multiplier among NREQ requesters.
// Grants one operand pair in IDLE, multiplies in EXEC, holds the product in DONE until accepted.
module gf8_mul_arbiter #(
  parameter int NREQ = 4,
  parameter logic [7:0] POLY = 8'h1B,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [8*NREQ-1:0] req_a,
  input  logic [8*NREQ-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [7:0]        rsp_y,
  output logic [IDW-1:0]    rsp_id,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d, id_q, id_d, rsp_id_q, rsp_id_d, gnt_id;
  logic [7:0] a_q, a_d, b_q, b_d, rsp_y_q, rsp_y_d, a_sel, b_sel;
  logic rsp_valid_q, rsp_valid_d, busy_q, busy_d, gnt;

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p, s;
    p = '0;
    s = x;
    for (int i = 0; i < 8; i++) begin
      p = y[i] ? p ^ s : p;
      s = s[7] ? {s[6:0], 1'b0} ^ POLY : {s[6:0], 1'b0};
    end
    return p;
  endfunction

  // Descending scan so the requester closest to ptr is the last (winning) assignment.
  always_comb begin
    gnt = 1'b0;
    gnt_id = '0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (state_q == IDLE && !rst && req_valid[IDW'((int'(ptr_q) + k) % NREQ)]) begin
        gnt = 1'b1;
        gnt_id = IDW'((int'(ptr_q) + k) % NREQ);
      end
  end

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NREQ; i++)
      if (gnt_id == IDW'(i)) begin
        a_sel = req_a[8*i +: 8];
        b_sel = req_b[8*i +: 8];
      end
  end

  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    a_d = a_q;
    b_d = b_q;
    id_d = id_q;
    rsp_y_d = rsp_y_q;
    rsp_id_d = rsp_id_q;
    rsp_valid_d = rsp_valid_q;
    busy_d = busy_q;
    if (gnt) begin
      state_d = EXEC;
      ptr_d = IDW'((int'(gnt_id) + 1) % NREQ);
      a_d = a_sel;
      b_d = b_sel;
      id_d = gnt_id;
      busy_d = 1'b1;
    end else if (state_q == EXEC) begin
      state_d = DONE;
      rsp_y_d = gf_mul(a_q, b_q);
      rsp_id_d = id_q;
      rsp_valid_d = 1'b1;
    end else if (state_q == DONE && rsp_ready) begin
      state_d = IDLE;
      rsp_valid_d = 1'b0;
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      ptr_q <= '0;
      a_q <= '0;
      b_q <= '0;
      id_q <= '0;
      rsp_y_q <= '0;
      rsp_id_q <= '0;
      rsp_valid_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      a_q <= a_d;
      b_q <= b_d;
      id_q <= id_d;
      rsp_y_q <= rsp_y_d;
      rsp_id_q <= rsp_id_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q <= busy_d;
    end

  assign req_ready = gnt ? NREQ'(1) << gnt_id : '0;
  assign rsp_valid = rsp_valid_q;
  assign rsp_y = rsp_y_q;
  assign rsp_id = rsp_id_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_gf8_mul_arbiter.sv
// tb_gf8_mul_arbiter: directed and randomized checks of gf8_mul_arbiter against a transaction-level model.
module tb_gf8_mul_arbiter;
  localparam int N = 4;
  localparam logic [7:0] POLY = 8'h1B;
  logic clk = 1'b0, rst, rsp_valid, rsp_ready, busy;
  logic [N-1:0] req_valid, req_ready, last_rdy, pend;
  logic [8*N-1:0] req_a, req_b;
  logic [7:0] rsp_y, m_a, m_b, m_y, y_hold;
  logic [1:0] rsp_id;
  int n_tests = 0, n_fail = 0;
  int m_ptr, m_age, m_rv, m_id, m_idx, cnt;
  int q[$];
  int rr_exp[5] = '{0, 1, 2, 3, 0};

  gf8_mul_arbiter #(.NREQ(N), .POLY(POLY)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_y(rsp_y), .rsp_id(rsp_id), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Carry-less product followed by polynomial long division by x^8+POLY.
  function automatic logic [7:0] gf_ref(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p ^= 15'(a) << i;
    for (int i = 14; i >= 8; i--) if (p[i]) p ^= 15'({1'b1, POLY}) << (i - 8);
    return p[7:0];
  endfunction

  task automatic model_reset;
    m_ptr = 0; m_age = -1; m_rv = 0; m_y = 0; m_id = 0;
  endtask

  // Called at posedge+1: drive, check before the next edge, then advance the model past that edge.
  task automatic cycle(input logic [N-1:0] v, input logic rr);
    logic [N-1:0] exp_rdy;
    int g;
    req_valid = v;
    rsp_ready = rr;
    exp_rdy = '0;
    g = -1;
    if (m_age < 0)
      for (int k = 0; k < N; k++)
        if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    if (g >= 0) exp_rdy[g] = 1'b1;
    #3;
    last_rdy = req_ready;
    chk("req_ready", req_ready, exp_rdy);
    chk("busy", busy, m_age >= 0);
    chk("rsp_valid", rsp_valid, m_rv);
    if (m_rv != 0) begin
      chk("rsp_y", rsp_y, m_y);
      chk("rsp_id", rsp_id, m_id);
    end
    @(posedge clk);
    #1;
    if (m_age < 0) begin
      if (g >= 0) begin
        m_a = req_a[8*g +: 8];
        m_b = req_b[8*g +: 8];
        m_idx = g;
        m_ptr = (g + 1) % N;
        m_age = 0;
      end
    end else if (m_age == 0) begin
      m_age = 1; m_rv = 1; m_y = gf_ref(m_a, m_b); m_id = m_idx;
    end else if (rr) begin
      m_age = -1; m_rv = 0;
    end
  endtask

  task automatic set_op(input int r, input logic [7:0] a, input logic [7:0] b);
    req_a[8*r +: 8] = a;
    req_b[8*r +: 8] = b;
  endtask

  task automatic op(input int r, input logic [7:0] a, input logic [7:0] b, input logic [7:0] y);
    set_op(r, a, b);
    cycle(N'(1) << r, 1'b1);
    chk("op_grant", last_rdy, N'(1) << r);
    cycle('0, 1'b1);
    chk("op_valid", rsp_valid, 1);
    chk("op_y", rsp_y, y);
    chk("op_id", rsp_id, r);
    cycle('0, 1'b1);
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0; req_a = '0; req_b = '0; last_rdy = '0;
    #2 req_valid = '1;
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_y", rsp_y, 0);
    chk("rst_id", rsp_id, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_valid = '0;
    model_reset();
    op(0, 8'h57, 8'h83, 8'hC1);
    op(2, 8'h02, 8'h80, 8'h1B);
    op(2, 8'h57, 8'h13, 8'hFE);
    op(1, 8'h00, 8'hFF, 8'h00);
    op(3, 8'h01, 8'hA5, 8'hA5);
    for (int i = 0; i < N; i++) set_op(i, 8'(8'h31 * (i + 1)), 8'(8'hC7 + 16 * i));
    for (int t = 0; t < 15; t++) begin
      cycle('1, 1'b1);
      if (last_rdy != 0) q.push_back($clog2(last_rdy));
    end
    chk("rr_count", q.size(), 5);
    for (int i = 0; i < 5; i++) if (q.size() > i) chk("rr_order", q[i], rr_exp[i]);
    set_op(1, 8'hCA, 8'h53);
    cycle(4'b0010, 1'b1);
    cycle('0, 1'b0);
    y_hold = rsp_y;
    chk("bp_y_first", y_hold, gf_ref(8'hCA, 8'h53));
    for (int t = 0; t < 5; t++) begin
      cycle('1, 1'b0);
      chk("bp_y_stable", rsp_y, y_hold);
      chk("bp_no_grant", last_rdy, 0);
    end
    cycle('1, 1'b1);
    chk("bp_hs_no_grant", last_rdy, 0);
    cycle('1, 1'b1);
    chk("bp_next_grant", last_rdy != 0, 1);
    cycle('0, 1'b1);
    cycle('0, 1'b1);
    cycle(4'b0100, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_valid", rsp_valid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_ready", req_ready, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle('1, 1'b1);
    chk("rst_first_grant", last_rdy, 4'b0001);
    for (int t = 0; t < 4; t++) cycle('0, 1'b1);
    cnt = 0;
    cycle(4'b0001, 1'b1);
    cycle(4'b0010, 1'b1);
    cnt += int'(last_rdy[1]);
    cycle(4'b0010, 1'b1);
    cnt += int'(last_rdy[1]);
    for (int t = 0; t < 4; t++) begin
      cycle('0, 1'b1);
      cnt += int'(last_rdy[1]);
      chk("withdraw_no_rsp", rsp_valid, 0);
    end
    chk("withdraw_no_grant", cnt, 0);
    pend = '0;
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < N; i++)
        if (pend[i] && $urandom_range(0, 9) == 0) pend[i] = 1'b0;
        else if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          set_op(i, 8'($urandom), 8'($urandom_range(0, 7) == 0 ? $urandom_range(0, 1) : $urandom));
        end
      cycle(pend, $urandom_range(0, 3) != 0);
      pend &= ~last_rdy;
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
